// File: rtl/key_event_queue.sv
// key_event_queue: synchronizes lane buttons, detects press/hold/release and queues them in a small event FIFO
module key_event_queue #(
  parameter int LANES    = 4,
  parameter int TICK_DIV = 100000,
  parameter int HOLD_MS  = 500,
  parameter int DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] pb_level,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [2:0]       ev_lane,
  output logic [1:0]       ev_type,
  output logic [LANES-1:0] held,
  output logic             overflow
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_MS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [LANES-1:0] r_s1, r_s2, r_prev, r_press, r_hold, r_rel;
  logic [PW-1:0]    r_pre;
  logic [HW-1:0]    r_cnt [LANES];
  logic [2:0]       r_lane_q [DEPTH];
  logic [1:0]       r_type_q [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             w_tick, w_found, w_push, w_pop;
  logic [LANES-1:0] w_rise, w_fall, w_hold_ev, w_sel, w_gp, w_gh, w_gr;
  logic [2:0]       w_lane;
  logic [1:0]       w_type;
  assign w_tick = r_pre == PW'(TICK_DIV - 1);
  assign w_rise = r_s2 & ~r_prev;
  assign w_fall = ~r_s2 & r_prev;
  always_comb begin
    w_hold_ev = '0;
    for (int l = 0; l < LANES; l++)
      w_hold_ev[l] = r_s2[l] & ~w_rise[l] & w_tick & (r_cnt[l] == HW'(HOLD_MS - 1));
  end
  // scanning downward lets the lowest pending lane win
  always_comb begin
    w_found = 1'b0;
    w_lane  = 3'd0;
    w_type  = 2'd0;
    w_sel   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (r_press[l] | r_hold[l] | r_rel[l]) begin
        w_found = 1'b1;
        w_lane  = 3'(l);
        w_type  = r_press[l] ? 2'd0 : r_hold[l] ? 2'd2 : 2'd1;
        w_sel   = LANES'(1) << l;
      end
    end
  end
  assign w_push = w_found & (r_count < CW'(DEPTH));
  assign w_pop  = ev_valid & ev_ready;
  assign w_gp   = (w_push && w_type == 2'd0) ? w_sel : '0;
  assign w_gh   = (w_push && w_type == 2'd2) ? w_sel : '0;
  assign w_gr   = (w_push && w_type == 2'd1) ? w_sel : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
      r_pre   <= '0;
      r_press <= '0;
      r_hold  <= '0;
      r_rel   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_s1    <= pb_level;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_pre   <= w_tick ? '0 : r_pre + PW'(1);
      r_press <= (r_press & ~w_gp) | w_rise;
      r_hold  <= (r_hold & ~w_gh) | w_hold_ev;
      r_rel   <= (r_rel & ~w_gr) | w_fall;
      // a flag still set after this edge's grant means the new event is lost
      r_ovf   <= r_ovf | (|((r_press & ~w_gp & w_rise) | (r_hold & ~w_gh & w_hold_ev) | (r_rel & ~w_gr & w_fall)));
    end
  end
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (rst || w_rise[l] || w_fall[l])
        r_cnt[l] <= '0;
      else if (r_s2[l] && w_tick && r_cnt[l] < HW'(HOLD_MS))
        r_cnt[l] <= r_cnt[l] + HW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_lane_q[i] <= 3'd0;
        r_type_q[i] <= 2'd0;
      end
    end else begin
      if (w_push) begin
        r_lane_q[r_wp] <= w_lane;
        r_type_q[r_wp] <= w_type;
        r_wp           <= r_wp + AW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  assign ev_valid = r_count != '0;
  assign ev_lane  = r_lane_q[r_rp];
  assign ev_type  = r_type_q[r_rp];
  assign held     = r_s2;
  assign overflow = r_ovf;
endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter LANES, default 4, number of game-lane buttons (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 100000, clk cycles per 1 ms tick.
REQ-003 SHALL have parameter HOLD_MS, default 500, tick count after press that produces a hold event.
REQ-004 SHALL have parameter DEPTH, default 4, event FIFO entries (power of two).
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port pb_level  input  LANES  debounced button levels from pbdebounce (slow-clock domain, treated as asynchronous).
REQ-008 SHALL have port ev_valid  output  1  FIFO head holds an event.
REQ-009 SHALL have port ev_ready  input  1  consumer accepts head; pop when ev_valid & ev_ready at a clk edge.
REQ-010 SHALL have port ev_lane  output  3  lane index of head event.
REQ-011 SHALL have port ev_type  output  2  head type: 00 press, 01 release, 10 hold; 11 never produced.
REQ-012 SHALL have port held  output  LANES  synchronized current level per lane.
REQ-013 SHALL have port overflow  output  1  sticky: an event was lost.

Function
REQ-014 Each pb_level bit SHALL pass a 2-flop synchronizer; a third register (prev) holds the previous synchronized value; held = synchronized value.
REQ-015 Rising synchronized edge SHALL set that lane's press-pending flag; falling edge SHALL set release-pending, one clk after detection.
REQ-016 A prescaler SHALL count 0..TICK_DIV-1 and wrap, asserting a one-cycle tick on the TICK_DIV-1 count.
REQ-017 Per-lane hold counter SHALL clear on rising edge, increment on tick while level high, saturate at HOLD_MS; on reaching HOLD_MS it SHALL set hold-pending exactly once per press.
REQ-018 Falling edge before HOLD_MS SHALL clear the hold counter with no hold event.
REQ-019 If an event arrives while its own pending flag is already set, the event SHALL be dropped and overflow set to 1.
REQ-020 Arbiter SHALL write at most one event per cycle into the FIFO when count < DEPTH, regardless of a same-cycle pop.
REQ-021 Arbiter SHALL select the lowest-index lane with any pending flag; within a lane order press, hold, release; the written flag clears the same edge.
REQ-022 FIFO SHALL be first-in first-out; ev_lane/ev_type driven from head storage, ev_valid = (count != 0); outputs stable while ev_valid & !ev_ready.
REQ-023 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-024 With empty FIFO and no other pending events, ev_valid SHALL rise after the 4th rising clk edge counting the edge that first samples the new pb_level.

Reset
REQ-025 rst high at a clk edge SHALL clear synchronizers, prev, pending flags, hold counters, prescaler, FIFO pointers and count, and overflow; ev_valid=0, ev_lane=0, ev_type=00, held=0.
REQ-026 Reset mid-operation SHALL discard all queued and pending events; no event from before reset SHALL appear after.
REQ-027 A lane already high when rst deasserts SHALL yield a press event via normal edge detection.

Verification
REQ-028 Lane 2 rises, ev_ready=1 -> ev_valid one cycle at edge+4, ev_lane=2, ev_type=00; fall -> one event type 01.
REQ-029 TICK_DIV=4, HOLD_MS=3, lane 0 held 20 cycles -> press, then exactly one hold (type 10) ~12 cycles after press, no repeat; release -> type 01.
REQ-030 Lanes 1 and 3 rise same cycle -> press lane 1 then press lane 3 on consecutive cycles.
REQ-031 ev_ready=0, 5 distinct presses/releases -> FIFO holds 4, fifth waits pending; duplicate press on pending lane -> overflow=1; drain -> order preserved.
REQ-032 rst pulsed with 3 events queued -> ev_valid=0 next cycle, overflow=0, queued events never appear.
